spike_rate_encoder: RTL and testbench
=====================================

SPIKE_RATE_ENCODER -- requirements
Module: spike_rate_encoder

Interface
REQ-001 SHALL have parameter N_CHANNELS, default 8, meaning number of spike outputs, equal to the neuron input vector width.
REQ-002 SHALL have parameter INTENSITY_W, default 4, meaning width of each channel's unsigned intensity.
REQ-003 SHALL have parameter N_TIMESTEPS, default 16, range 1..256, meaning steps per encoding window.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port wr_en  in  1  intensity write strobe.
REQ-007 SHALL have port wr_addr  in  clog2(N_CHANNELS)  channel index of the write.
REQ-008 SHALL have port wr_data  in  INTENSITY_W  unsigned intensity to store.
REQ-009 SHALL have port start  in  1  single-cycle request to begin an encoding window.
REQ-010 SHALL have port step_en  in  1  advance one timestep; low stalls the encoder (downstream backpressure).
REQ-011 SHALL have port abort  in  1  terminate the current window.
REQ-012 SHALL have port spikes  out  N_CHANNELS  registered spike vector for the neuron inputs.
REQ-013 SHALL have port spikes_valid  out  1  one-cycle pulse, spikes holds a new timestep.
REQ-014 SHALL have port timestep  out  8  index of the timestep currently presented on spikes.
REQ-015 SHALL have port busy  out  1  high while state is RUN.
REQ-016 SHALL have port done  out  1  one-cycle pulse after the last timestep of a window.

Function
REQ-017 SHALL implement FSM states IDLE and RUN.
REQ-018 SHALL leave IDLE for RUN on start=1, clearing all accumulators to 0 and the step counter to 0 in the same edge.
REQ-019 SHALL ignore step_en in IDLE, including in the cycle where start=1.
REQ-020 SHALL ignore start while in RUN.
REQ-021 SHALL, on each RUN cycle with step_en=1, set every acc[i] to the low INTENSITY_W bits of acc[i]+intensity[i] and set spikes[i] to the carry-out of that sum (first-order sigma-delta).
REQ-022 SHALL assert spikes_valid for exactly one cycle, one cycle after each accepted step, with timestep equal to that step's index (0-based).
REQ-023 SHALL hold spikes, acc, and the counter unchanged when step_en=0, and deassert spikes_valid.
REQ-024 SHALL, on the accepted step with index N_TIMESTEPS-1, return to IDLE and pulse done together with that step's spikes_valid.
REQ-025 SHALL produce sum(spikes[i]) over a window equal to floor(intensity[i]*N_TIMESTEPS/2^INTENSITY_W), which is exact when N_TIMESTEPS is a multiple of 2^INTENSITY_W.
REQ-026 SHALL write intensity[wr_addr] on wr_en in any state; a write in RUN affects steps accepted from the next cycle on.
REQ-027 SHALL, when a write and a step occur in the same cycle, use the old intensity for that step.
REQ-028 SHALL ignore writes with wr_addr >= N_CHANNELS.
REQ-029 SHALL, on abort in RUN, go to IDLE and clear spikes and accumulators without pulsing done or spikes_valid; abort overrides step_en and start.
REQ-030 SHALL keep spikes at its last value in IDLE after a normal window completes.

Reset
REQ-031 SHALL, on reset, force IDLE, and set acc, intensity, spikes, spikes_valid, done and timestep to 0 and busy to 0, asynchronously and irrespective of clk.
REQ-032 SHALL drop a window in progress on reset without pulsing done.

Structure
REQ-033 SHALL place the FSM state encoding and the default constants (N_CHANNELS, INTENSITY_W, N_TIMESTEPS) in the shared package spike_encoder_pkg.
REQ-034 SHALL instantiate a per-channel sub-module encoder_channel (intensity register, accumulator, carry-out) N_CHANNELS times; the FSM and counter reside in the top module.

Verification
REQ-035 SHALL cover: intensities 0,1,4,8,15 on ch0..4, start, step_en=1 for 16 cycles -> spike counts 0,1,4,8,15; ch3 alternates 0,1; done coincides with timestep=15.
REQ-036 SHALL cover: ch0 intensity 15, step_en toggled 1,0,1,0 -> spikes_valid only after the accepted steps; spikes and timestep frozen during stalls.
REQ-037 SHALL cover: start and step_en both 1 in IDLE -> only the state changes; first spikes_valid follows the next accepted step with timestep=0.
REQ-038 SHALL cover: abort at timestep 5 -> busy=0 next cycle, spikes=0, no done; a new start gives ch-accurate counts from zero accumulators.
REQ-039 SHALL cover: write ch2 8->15 at the same edge as step 7 -> step 7 uses 8, steps 8..15 use 15; total matches the hand-computed sigma-delta result.
REQ-040 SHALL cover: reset asserted mid-window between clock edges -> all outputs 0 immediately; no done pulse after release.

Source files
------------

// File: rtl/spike_encoder_pkg.sv
// Shared definitions for the spike rate encoder.
//   - Default sizing constants for the encoder and its channels.
//   - FSM state encoding for the encoding-window controller.
//   - addr_width(): width of a channel index; it never returns 0, so a
//     single-channel build still has a 1-bit address port.
package spike_encoder_pkg;

  localparam int unsigned DEF_N_CHANNELS  = 8;
  localparam int unsigned DEF_INTENSITY_W = 4;
  localparam int unsigned DEF_N_TIMESTEPS = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } enc_state_t;

  function automatic int unsigned addr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spike_rate_encoder_channel.sv
// One channel of the spike rate encoder: a first-order sigma-delta modulator.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   wr_en       - load wr_data into the intensity register
//   wr_data     - unsigned intensity
//   acc_clr     - clear the accumulator (window start or abort)
//   spike_clr   - clear the spike output (abort)
//   step        - accept one timestep: acc += intensity, spike = carry-out
//   spike       - registered spike for this channel
// A step uses the intensity held before any write in the same cycle.
module encoder_channel
  import spike_encoder_pkg::*;
#(
  parameter int unsigned INTENSITY_W = DEF_INTENSITY_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [INTENSITY_W-1:0] wr_data,
  input  logic                   acc_clr,
  input  logic                   spike_clr,
  input  logic                   step,
  output logic                   spike
);

  logic [INTENSITY_W-1:0] intensity;
  logic [INTENSITY_W-1:0] acc;
  logic [INTENSITY_W:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, intensity};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      intensity <= '0;
    end else if (wr_en) begin
      intensity <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc   <= '0;
      spike <= 1'b0;
    end else begin
      if (acc_clr) begin
        acc <= '0;
      end else if (step) begin
        acc <= sum[INTENSITY_W-1:0];
      end
      if (spike_clr) begin
        spike <= 1'b0;
      end else if (step) begin
        spike <= sum[INTENSITY_W];
      end
    end
  end

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate-coded spike encoder: converts per-channel intensities into spike trains
// over a window of N_TIMESTEPS steps (spike count ~ intensity*N/2^W).
// Ports:
//   clk, reset           - clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data - intensity write (any state; bad addresses ignored)
//   start                - begin a window (IDLE only)
//   step_en              - advance one timestep; low stalls
//   abort                - end the window, clearing spikes and accumulators
//   spikes/spikes_valid  - registered spike vector and its one-cycle strobe
//   timestep             - index of the step presented on spikes
//   busy                 - window in progress
//   done                 - pulses with the last step's spikes_valid
module spike_rate_encoder
  import spike_encoder_pkg::*;
#(
  parameter int unsigned N_CHANNELS  = DEF_N_CHANNELS,
  parameter int unsigned INTENSITY_W = DEF_INTENSITY_W,
  parameter int unsigned N_TIMESTEPS = DEF_N_TIMESTEPS
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                wr_en,
  input  logic [addr_width(N_CHANNELS)-1:0]   wr_addr,
  input  logic [INTENSITY_W-1:0]              wr_data,
  input  logic                                start,
  input  logic                                step_en,
  input  logic                                abort,
  output logic [N_CHANNELS-1:0]               spikes,
  output logic                                spikes_valid,
  output logic [7:0]                          timestep,
  output logic                                busy,
  output logic                                done
);

  localparam int unsigned ADDR_W    = addr_width(N_CHANNELS);
  localparam logic [7:0]  LAST_STEP = 8'(N_TIMESTEPS - 1);

  enc_state_t state, state_nx;
  logic [7:0] step_cnt;
  logic       accept;
  logic       begin_win;
  logic       kill;
  logic       last_step;

  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    begin_win = 1'b0;
    kill      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx  = RUN;
          begin_win = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_nx = IDLE;
          kill     = 1'b1;
        end else if (step_en) begin
          accept = 1'b1;
          if (step_cnt == LAST_STEP) begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign last_step = accept && (step_cnt == LAST_STEP);
  assign busy      = (state == RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_cnt     <= '0;
      timestep     <= '0;
      spikes_valid <= 1'b0;
      done         <= 1'b0;
    end else begin
      spikes_valid <= accept;
      done         <= last_step;
      if (begin_win) begin
        step_cnt <= '0;
      end else if (accept) begin
        step_cnt <= step_cnt + 8'd1;
        timestep <= step_cnt;
      end
    end
  end

  // Out-of-range addresses match no channel, so those writes are dropped.
  for (genvar i = 0; i < N_CHANNELS; i++) begin : g_ch
    encoder_channel #(
      .INTENSITY_W(INTENSITY_W)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en && (wr_addr == ADDR_W'(i))),
      .wr_data  (wr_data),
      .acc_clr  (begin_win || kill),
      .spike_clr(kill),
      .step     (accept),
      .spike    (spikes[i])
    );
  end

endmodule

// File: tb/tb_spike_rate_encoder.sv
module tb_spike_rate_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic       start;
  logic       step_en;
  logic       abort;
  logic [7:0] spikes;
  logic       spikes_valid;
  logic [7:0] timestep;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  spike_rate_encoder #(
    .N_CHANNELS (8),
    .INTENSITY_W(4),
    .N_TIMESTEPS(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .start       (start),
    .step_en     (step_en),
    .abort       (abort),
    .spikes      (spikes),
    .spikes_valid(spikes_valid),
    .timestep    (timestep),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge: drive and sample point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int val);
    wr_en   = 1'b1;
    wr_addr = 3'(ch);
    wr_data = 4'(val);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; step_en = 1'b0; abort = 1'b0;
    #2;
    checks++;
    if ({spikes, spikes_valid, timestep, busy, done} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs: got spk=%h v=%b ts=%0d busy=%b done=%b, want all 0",
               spikes, spikes_valid, timestep, busy, done);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_rates();
    int cnt [5];
    int exp_cnt [5];
    exp_cnt = '{0, 1, 4, 8, 15};
    for (int c = 0; c < 5; c++) cnt[c] = 0;
    wr(0, 0); wr(1, 1); wr(2, 4); wr(3, 8); wr(4, 15);
    wr(5, 0); wr(6, 0); wr(7, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({busy, spikes_valid} !== 2'b10) begin
      errors++;
      $display("FAIL rates_start: got busy=%b v=%b, want busy=1 v=0", busy, spikes_valid);
    end
    step_en = 1'b1;
    for (int t = 0; t < 16; t++) begin
      tick();
      checks++;
      if ({spikes_valid, done, timestep} !== {1'b1, (t == 15), 8'(t)}) begin
        errors++;
        $display("FAIL rates_step%0d: got v=%b done=%b ts=%0d, want v=1 done=%b ts=%0d",
                 t, spikes_valid, done, timestep, (t == 15), t);
      end
      checks++;
      if (spikes[3] !== ((t % 2) == 1)) begin
        errors++;
        $display("FAIL rates_ch3_alt%0d: got %b want %b", t, spikes[3], ((t % 2) == 1));
      end
      for (int c = 0; c < 5; c++) cnt[c] += int'(spikes[c]);
    end
    step_en = 1'b0;
    tick();
    checks++;
    if ({spikes_valid, done, busy, spikes} !== {3'b000, 8'h1E}) begin
      errors++;
      $display("FAIL rates_idle_hold: got v=%b done=%b busy=%b spk=%h, want 0 0 0 1e",
               spikes_valid, done, busy, spikes);
    end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (cnt[c] != exp_cnt[c]) begin
        errors++;
        $display("FAIL rates_count_ch%0d: got %0d want %0d", c, cnt[c], exp_cnt[c]);
      end
    end
  endtask

  task automatic test_stall();
    logic       pat_en [4];
    logic       exp_v  [4];
    logic [7:0] exp_ts [4];
    logic [7:0] exp_sp [4];
    pat_en = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_v  = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_ts = '{8'd0, 8'd0, 8'd1, 8'd1};
    exp_sp = '{8'h00, 8'h00, 8'h01, 8'h01};
    wr(0, 15); wr(1, 0); wr(2, 0); wr(3, 0); wr(4, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step_en = pat_en[k];
      tick();
      checks++;
      if ({spikes_valid, timestep, spikes} !== {exp_v[k], exp_ts[k], exp_sp[k]}) begin
        errors++;
        $display("FAIL stall_cyc%0d: got v=%b ts=%0d spk=%h, want v=%b ts=%0d spk=%h",
                 k, spikes_valid, timestep, spikes, exp_v[k], exp_ts[k], exp_sp[k]);
      end
    end
    step_en = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_start_with_step();
    start = 1'b1;
    step_en = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({busy, spikes_valid} !== 2'b10) begin
      errors++;
      $display("FAIL startstep_state: got busy=%b v=%b, want busy=1 v=0", busy, spikes_valid);
    end
    tick();
    checks++;
    if ({spikes_valid, timestep, spikes} !== {1'b1, 8'd0, 8'h00}) begin
      errors++;
      $display("FAIL startstep_first: got v=%b ts=%0d spk=%h, want v=1 ts=0 spk=00",
               spikes_valid, timestep, spikes);
    end
    step_en = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_abort();
    int cnt [3];
    int exp_cnt [3];
    int done_seen;
    exp_cnt = '{15, 8, 5};
    done_seen = 0;
    wr(0, 15); wr(1, 8); wr(2, 5);
    start = 1'b1;
    tick();
    start = 1'b0;
    step_en = 1'b1;
    for (int t = 0; t < 6; t++) tick();
    checks++;
    if ({timestep, spikes_valid} !== {8'd5, 1'b1}) begin
      errors++;
      $display("FAIL abort_pre: got ts=%0d v=%b, want ts=5 v=1", timestep, spikes_valid);
    end
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    checks++;
    if ({busy, spikes, spikes_valid, done} !== 11'd0) begin
      errors++;
      $display("FAIL abort_post: got busy=%b spk=%h v=%b done=%b, want all 0",
               busy, spikes, spikes_valid, done);
    end
    step_en = 1'b0;
    for (int t = 0; t < 3; t++) begin
      tick();
      if (done === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d done pulses want 0", done_seen);
    end
    for (int c = 0; c < 3; c++) cnt[c] = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    step_en = 1'b1;
    for (int t = 0; t < 16; t++) begin
      tick();
      for (int c = 0; c < 3; c++) cnt[c] += int'(spikes[c]);
    end
    step_en = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL abort_rerun_done: got %b want 1", done);
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (cnt[c] != exp_cnt[c]) begin
        errors++;
        $display("FAIL abort_rerun_ch%0d: got %0d want %0d", c, cnt[c], exp_cnt[c]);
      end
    end
    tick();
  endtask

  task automatic test_write_in_run();
    int cnt2;
    cnt2 = 0;
    wr(0, 0); wr(1, 0); wr(2, 8);
    start = 1'b1;
    tick();
    start = 1'b0;
    step_en = 1'b1;
    for (int t = 0; t < 16; t++) begin
      if (t == 7) begin
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'd15;
      end
      tick();
      wr_en = 1'b0;
      cnt2 += int'(spikes[2]);
      if (t == 7) begin
        checks++;
        if (spikes[2] !== 1'b1) begin
          errors++;
          $display("FAIL wrrun_step7: got %b want 1", spikes[2]);
        end
      end
      if (t == 8) begin
        checks++;
        if (spikes[2] !== 1'b0) begin
          errors++;
          $display("FAIL wrrun_step8: got %b want 0", spikes[2]);
        end
      end
    end
    step_en = 1'b0;
    checks++;
    if (cnt2 != 11) begin
      errors++;
      $display("FAIL wrrun_total: got %0d want 11", cnt2);
    end
    tick();
  endtask

  task automatic test_reset_mid_window();
    int done_seen;
    int cnt0;
    done_seen = 0;
    cnt0 = 0;
    wr(0, 15); wr(1, 0); wr(2, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    step_en = 1'b1;
    for (int t = 0; t < 4; t++) tick();
    checks++;
    if ({spikes, timestep, spikes_valid} !== {8'h01, 8'd3, 1'b1}) begin
      errors++;
      $display("FAIL rstmid_pre: got spk=%h ts=%0d v=%b, want 01 3 1", spikes, timestep, spikes_valid);
    end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({spikes, spikes_valid, timestep, busy, done} !== 19'd0) begin
      errors++;
      $display("FAIL rstmid_async: got spk=%h v=%b ts=%0d busy=%b done=%b, want all 0",
               spikes, spikes_valid, timestep, busy, done);
    end
    tick();
    reset = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      errors++;
      $display("FAIL rstmid_no_done: got %0d done/busy cycles want 0", done_seen);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 16; t++) begin
      tick();
      cnt0 += int'(spikes[0]);
    end
    step_en = 1'b0;
    checks++;
    if (cnt0 != 0) begin
      errors++;
      $display("FAIL rstmid_intensity_cleared: got %0d spikes want 0", cnt0);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_rates();
    test_stall();
    test_start_with_step();
    test_abort();
    test_write_in_run();
    test_reset_mid_window();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
